// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants and state encoding for the BN result latch
package acc_pkg;

   localparam int N       = 8;
   localparam int RES_W   = 4 * N;
   localparam int NUM_RES = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2,
      ST_HOLD = 2'd3
   } acc_state_t;

endpackage

// File: rtl/acc_scan_seq.sv
// rtl/acc_scan_seq.sv - auto-scan divider with word/byte select counters
module acc_scan_seq
   import acc_pkg::*;
#(
   parameter int SCAN_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       auto_scan,
   output logic [3:0] word_sel,
   output logic [1:0] byte_sel
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       WORD_MAX = 4'(NUM_RES - 1);

   logic [DIV_W-1:0] div_q;
   logic             auto_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         word_sel <= '0;
         byte_sel <= '0;
         auto_q   <= 1'b0;
      end else begin
         auto_q <= auto_scan;
         // A fresh entry into auto mode always starts the scan at word 0 byte 0
         if (auto_scan && !auto_q) begin
            div_q    <= '0;
            word_sel <= '0;
            byte_sel <= '0;
         end else if (div_q == DIV_MAX) begin
            div_q <= '0;
            if (byte_sel == 2'd3) begin
               byte_sel <= 2'd0;
               word_sel <= (word_sel == WORD_MAX) ? 4'd0 : word_sel + 4'd1;
            end else begin
               byte_sel <= byte_sel + 2'd1;
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/acc_result_latch.sv
// rtl/acc_result_latch.sv - timed capture of BN results and byte display on LEDs
module acc_result_latch
   import acc_pkg::*;
#(
   parameter int LAT      = 10,
   parameter int SCAN_DIV = 25000000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [NUM_RES*RES_W-1:0] res_flat,
   input  logic [3:0]               sw_idx,
   input  logic [1:0]               sw_byte,
   input  logic                     auto_scan,
   output logic                     busy,
   output logic                     done,
   output logic                     idx_err,
   output logic [7:0]               led
);

   localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

   acc_state_t       state, next_state;
   logic [7:0]       cnt, next_cnt;
   logic             capture;
   logic [RES_W-1:0] buf_q [NUM_RES];

   logic [3:0]       scan_word, word_sel;
   logic [1:0]       scan_byte, byte_sel;
   logic [RES_W-1:0] sel_word;
   logic [7:0]       sel_byte;
   logic             idx_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // A start seen in any state relaunches the wait; the latest launch wins
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_WAIT;
               next_cnt   = '0;
            end
         end
         ST_WAIT: begin
            if (start) begin
               next_cnt = '0;
            end else if (cnt == LAT_M1) begin
               next_state = ST_CAPT;
            end else begin
               next_cnt = cnt + 8'd1;
            end
         end
         ST_CAPT: begin
            capture = 1'b1;
            if (start) begin
               next_state = ST_WAIT;
               next_cnt   = '0;
            end else begin
               next_state = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (start) begin
               next_state = ST_WAIT;
               next_cnt   = '0;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_WAIT) || (state == ST_CAPT);
   assign done = (state == ST_HOLD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_RES; k++) buf_q[k] <= '0;
      end else if (capture) begin
         for (int k = 0; k < NUM_RES; k++) buf_q[k] <= res_flat[k*RES_W +: RES_W];
      end
   end

   acc_scan_seq #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk       (clk),
      .rst_n     (reset_n),
      .auto_scan (auto_scan),
      .word_sel  (scan_word),
      .byte_sel  (scan_byte)
   );

   assign word_sel = auto_scan ? scan_word : sw_idx;
   assign byte_sel = auto_scan ? scan_byte : sw_byte;
   assign idx_bad  = ({1'b0, word_sel} >= 5'(NUM_RES));

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_RES; k++) begin
         if (word_sel == 4'(k)) sel_word = buf_q[k];
      end
      case (byte_sel)
         2'd0:    sel_byte = sel_word[7:0];
         2'd1:    sel_byte = sel_word[15:8];
         2'd2:    sel_byte = sel_word[23:16];
         default: sel_byte = sel_word[31:24];
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led     <= 8'h00;
         idx_err <= 1'b0;
      end else begin
         led     <= idx_bad ? 8'hFF : sel_byte;
         idx_err <= idx_bad;
      end
   end

endmodule

// File: tb/tb_acc_result_latch.sv
// tb/tb_acc_result_latch.sv - directed self-checking bench for acc_result_latch
module tb_acc_result_latch;
   import acc_pkg::*;

   localparam int LAT = 10;
   localparam int SCAN_DIV = 4;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     start;
   logic [NUM_RES*RES_W-1:0] res_flat;
   logic [3:0]               sw_idx;
   logic [1:0]               sw_byte;
   logic                     auto_scan;
   logic                     busy, done, idx_err;
   logic [7:0]               led;

   int n_assert = 0;
   int n_fail   = 0;

   acc_result_latch #(.LAT(LAT), .SCAN_DIV(SCAN_DIV)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .res_flat  (res_flat),
      .sw_idx    (sw_idx),
      .sw_byte   (sw_byte),
      .auto_scan (auto_scan),
      .busy      (busy),
      .done      (done),
      .idx_err   (idx_err),
      .led       (led)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      res_flat  = '0;
      sw_idx    = 4'd0;
      sw_byte   = 2'd0;
      auto_scan = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_led", 32'(led), 32'h00);
      chk("rst_idx_err", 32'(idx_err), 32'd0);

      // first capture: word0 and word11 loaded
      res_flat[0*RES_W +: RES_W]  = 32'hA1B2C3D4;
      res_flat[11*RES_W +: RES_W] = 32'h11223344;
      sw_idx  = 4'd0;
      sw_byte = 2'd2;
      start   = 1'b1;
      step();
      start = 1'b0;
      chk("cap_busy_t0", 32'(busy), 32'd1);
      for (int i = 1; i <= LAT; i++) begin
         step();
         chk("cap_busy_wait", 32'(busy), 32'd1);
         chk("cap_done_wait", 32'(done), 32'd0);
      end
      step();
      chk("cap_done", 32'(done), 32'd1);
      chk("cap_busy_off", 32'(busy), 32'd0);
      chk("cap_led_pre", 32'(led), 32'h00);
      step();
      chk("cap_led_b2", 32'(led), 32'hB2);

      // buffer frozen while holding
      res_flat[0*RES_W +: RES_W] = 32'h0;
      step(); step();
      chk("iso_led", 32'(led), 32'hB2);
      chk("iso_done", 32'(done), 32'd1);

      sw_idx = 4'd11; sw_byte = 2'd0;
      step();
      chk("w11_led", 32'(led), 32'h44);
      chk("w11_err", 32'(idx_err), 32'd0);
      sw_idx = 4'd12;
      step();
      chk("w12_led", 32'(led), 32'hFF);
      chk("w12_err", 32'(idx_err), 32'd1);
      sw_idx = 4'd15; sw_byte = 2'd3;
      step();
      chk("w15_led", 32'(led), 32'hFF);
      chk("w15_err", 32'(idx_err), 32'd1);
      sw_idx = 4'd11;
      step();
      chk("w11b3_led", 32'(led), 32'h11);

      // restart from HOLD, then relaunch mid-wait
      res_flat[5*RES_W +: RES_W] = 32'h00000080;
      sw_idx = 4'd5; sw_byte = 2'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rs_done_clr", 32'(done), 32'd0);
      chk("rs_busy", 32'(busy), 32'd1);
      step();
      chk("rs_led_old", 32'(led), 32'h00);
      step(); step(); step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
         step();
         chk("rs_no_early_done", 32'(done), 32'd0);
      end
      step();
      chk("rs_done", 32'(done), 32'd1);
      step();
      chk("rs_led_80", 32'(led), 32'h80);

      // asynchronous reset during WAIT
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("ar_busy_pre", 32'(busy), 32'd1);
      chk("ar_led_pre", 32'(led), 32'h80);
      reset_n = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      chk("ar_led", 32'(led), 32'h00);
      step(); step();
      reset_n = 1'b1;
      for (int i = 0; i < LAT + 4; i++) begin
         step();
         chk("ar_idle_busy", 32'(busy), 32'd0);
         chk("ar_idle_done", 32'(done), 32'd0);
         chk("ar_buf_zero", 32'(led), 32'h00);
      end

      // auto-scan: byte b of word k holds 4k+b
      for (int k = 0; k < NUM_RES; k++)
         for (int b = 0; b < 4; b++)
            res_flat[k*RES_W + b*8 +: 8] = 8'(4*k + b);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < LAT + 1; i++) step();
      chk("as_done", 32'(done), 32'd1);
      sw_idx = 4'd15; sw_byte = 2'd3;
      auto_scan = 1'b1;
      step();
      for (int m = 1; m <= 200; m++) begin
         step();
         chk("as_led", 32'(led), 32'(((m - 1) / 4) % 48));
         chk("as_err", 32'(idx_err), 32'd0);
      end

      auto_scan = 1'b0;
      sw_idx = 4'd2; sw_byte = 2'd1;
      step(); step();
      chk("man_led", 32'(led), 32'h09);
      auto_scan = 1'b1;
      step();
      step();
      chk("reauto_led0", 32'(led), 32'h00);
      for (int i = 0; i < 4; i++) step();
      chk("reauto_led1", 32'(led), 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
